// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the IMEM boot loader.
//   boot_state_e   : loader FSM state encoding
//   HDR_BYTES      : bytes in the frame header (16-bit word count)
//   BYTES_PER_WORD : payload bytes per instruction word
//   BYTE_IDX_W     : width of the in-word byte index
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_LOAD   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } boot_state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  // States in which the loader accepts stream bytes.
  function automatic logic state_accepts(input boot_state_e st);
    return (st == ST_IDLE) || (st == ST_HDR_HI) ||
           (st == ST_LOAD) || (st == ST_CSUM);
  endfunction

endpackage

// File: rtl/imem_boot_loader_byte_to_word_packer.sv
// Assembles little-endian 32-bit words from an accepted byte stream.
//   clk, rst    : clock, synchronous active-high reset
//   clear       : return to byte 0 (start of a new load)
//   byte_in     : payload byte
//   accept      : byte_in is taken this cycle
//   word        : completed word, valid while word_valid is high
//   word_valid  : high in the cycle the 4th byte of a word is accepted
// Only the first three bytes are stored; the 4th byte is merged
// combinationally so the caller can capture the whole word on the same
// edge and the assembly register is free for the next byte immediately.
module byte_to_word_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        accept,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [BYTE_IDX_W-1:0] byte_idx_q;
  logic [23:0]           asm_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_idx_q <= '0;
      asm_q      <= '0;
    end else if (accept) begin
      case (byte_idx_q)
        2'd0:    asm_q[7:0]   <= byte_in;
        2'd1:    asm_q[15:8]  <= byte_in;
        2'd2:    asm_q[23:16] <= byte_in;
        default: asm_q        <= asm_q;
      endcase
      byte_idx_q <= byte_idx_q + 1'b1;
    end
  end

  assign word       = {byte_in, asm_q};
  assign word_valid = accept && (byte_idx_q == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// Framed byte-stream boot loader feeding the instruction memory.
//   clk, rst      : clock, synchronous active-high reset
//   in_data       : stream byte
//   in_valid      : in_data valid
//   in_ready      : loader accepts a byte (transfer on in_valid && in_ready)
//   reload        : pulse; from DONE/ERROR, return to IDLE
//   imem_we       : IMEM write strobe (single cycle)
//   imem_waddr    : IMEM word address
//   imem_wdata    : IMEM write data
//   core_run      : image loaded and checksum verified
//   load_err      : error flag, held until reload/reset
//   words_loaded  : words written in the current load
//
// state   | meaning
// IDLE    | waiting for word count low byte
// HDR_HI  | waiting for word count high byte, range check
// LOAD    | receiving payload bytes, writing words
// CSUM    | waiting for checksum byte
// DONE    | image verified, core running
// ERROR   | oversize frame or checksum mismatch
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_run,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  boot_state_e       state_q, state_d;
  logic [15:0]       n_q;
  logic [7:0]        csum_q;
  logic [ADDR_W:0]   word_cnt_q;
  logic [ADDR_W:0]   words_acc_q;
  logic              we_q;
  logic [31:0]       wdata_q;

  logic              acc;
  logic              go_idle;
  logic              load_acc;
  logic [15:0]       hdr_n;
  logic              last_word;
  logic [31:0]       pk_word;
  logic              pk_word_valid;

  assign acc      = in_valid && in_ready;
  assign go_idle  = reload && ((state_q == ST_DONE) || (state_q == ST_ERROR));
  assign load_acc = acc && (state_q == ST_LOAD);
  assign hdr_n    = {in_data, n_q[7:0]};
  // Words accepted so far plus the one completing now.
  assign last_word = ((16'(words_acc_q) + 16'd1) == n_q);

  byte_to_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (go_idle),
    .byte_in    (in_data),
    .accept     (load_acc),
    .word       (pk_word),
    .word_valid (pk_word_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = state_accepts(state_q);
    case (state_q)
      ST_IDLE: begin
        if (acc) state_d = ST_HDR_HI;
      end
      ST_HDR_HI: begin
        if (acc) begin
          if (hdr_n > 16'(MAX_WORDS))  state_d = ST_ERROR;
          else if (hdr_n == 16'd0)     state_d = ST_CSUM;
          else                         state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (pk_word_valid && last_word) state_d = ST_CSUM;
      end
      ST_CSUM: begin
        if (acc) state_d = (in_data == csum_q) ? ST_DONE : ST_ERROR;
      end
      ST_DONE, ST_ERROR: begin
        if (reload) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Header, checksum and word counters.
  always_ff @(posedge clk) begin
    if (rst || go_idle) begin
      n_q         <= '0;
      csum_q      <= '0;
      word_cnt_q  <= '0;
      words_acc_q <= '0;
    end else begin
      if (acc && (state_q == ST_IDLE))   n_q[7:0]  <= in_data;
      if (acc && (state_q == ST_HDR_HI)) n_q[15:8] <= in_data;
      if (load_acc)                      csum_q    <= csum_q ^ in_data;
      if (pk_word_valid)                 words_acc_q <= words_acc_q + 1'b1;
      // The count advances at the end of the write cycle so imem_waddr
      // still shows this word's address while imem_we is high.
      if (we_q)                          word_cnt_q <= word_cnt_q + 1'b1;
    end
  end

  // IMEM write register: second buffer behind the packer, so the write
  // lands one cycle after the 4th byte while new bytes keep flowing in.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      we_q <= pk_word_valid;
      if (pk_word_valid) wdata_q <= pk_word;
    end
  end

  assign imem_we      = we_q;
  assign imem_wdata   = wdata_q;
  assign imem_waddr   = word_cnt_q[ADDR_W-1:0];
  assign words_loaded = word_cnt_q;
  assign core_run     = (state_q == ST_DONE);
  assign load_err     = (state_q == ST_ERROR);

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              reload = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_run;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_n = 0;
  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];
  int          wr_cyc  [16];
  int base;

  imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .reload       (reload),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .core_run     (core_run),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Write log sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (wr_n < 16) begin
        wr_addr[wr_n] = 32'(imem_waddr);
        wr_data[wr_n] = imem_wdata;
        wr_cyc[wr_n]  = cyc;
      end
      wr_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for one clock edge, then idle for gap cycles.
  task automatic send(input logic [7:0] b, input int gap);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_core_run", 32'(core_run), 0);
    chk("rst_load_err", 32'(load_err), 0);
    chk("rst_imem_we", 32'(imem_we), 0);
    chk("rst_words_loaded", 32'(words_loaded), 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Nominal, back-to-back. Payload XOR = 13^93^10 = 0x90.
    send(8'h02, 0); send(8'h00, 0);
    send(8'h13, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    send(8'h93, 0); send(8'h00, 0); send(8'h10, 0); send(8'h00, 0);
    chk("nom_core_run_before_csum", 32'(core_run), 0);
    send(8'h90, 0);
    chk("nom_core_run", 32'(core_run), 1);
    chk("nom_words_loaded", 32'(words_loaded), 2);
    chk("nom_in_ready_done", 32'(in_ready), 0);
    chk("nom_load_err", 32'(load_err), 0);
    chk("nom_wr_count", 32'(wr_n), 2);
    chk("nom_addr0", wr_addr[0], 0);
    chk("nom_data0", wr_data[0], 32'h0000_0013);
    chk("nom_addr1", wr_addr[1], 1);
    chk("nom_data1", wr_data[1], 32'h0010_0093);
    chk("nom_write_spacing", 32'(wr_cyc[1] - wr_cyc[0]), 4);

    // DONE ignores input
    send(8'h55, 2);
    chk("done_ignore_wr", 32'(wr_n), 2);
    chk("done_hold_run", 32'(core_run), 1);

    // reload from DONE
    pulse_reload();
    chk("reload_core_run", 32'(core_run), 0);
    chk("reload_in_ready", 32'(in_ready), 1);
    chk("reload_words_loaded", 32'(words_loaded), 0);

    // Bad checksum with random gaps mid-word
    base = wr_n;
    send(8'h02, $urandom_range(0, 3)); send(8'h00, $urandom_range(0, 3));
    send(8'h13, $urandom_range(0, 3)); send(8'h00, $urandom_range(0, 3));
    send(8'h00, $urandom_range(0, 3)); send(8'h00, $urandom_range(0, 3));
    send(8'h93, $urandom_range(0, 3)); send(8'h00, $urandom_range(0, 3));
    send(8'h10, $urandom_range(0, 3)); send(8'h00, $urandom_range(0, 3));
    send(8'h91, 0);
    chk("bad_wr_count", 32'(wr_n - base), 2);
    chk("bad_addr0", wr_addr[base], 0);
    chk("bad_data0", wr_data[base], 32'h0000_0013);
    chk("bad_addr1", wr_addr[base+1], 1);
    chk("bad_data1", wr_data[base+1], 32'h0010_0093);
    chk("bad_load_err", 32'(load_err), 1);
    chk("bad_core_run", 32'(core_run), 0);
    chk("bad_in_ready", 32'(in_ready), 0);
    send(8'h00, 1);
    chk("err_hold", 32'(load_err), 1);
    pulse_reload();
    chk("reload_err_clear", 32'(load_err), 0);
    chk("reload_err_ready", 32'(in_ready), 1);

    // Oversize header N=65
    base = wr_n;
    send(8'h41, 0);
    chk("over_after_lo", 32'(load_err), 0);
    send(8'h00, 0);
    chk("over_load_err", 32'(load_err), 1);
    send(8'h13, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 3);
    chk("over_no_write", 32'(wr_n - base), 0);
    pulse_reload();

    // Boundary: N=64 is accepted into LOAD (no error after header)
    send(8'h40, 0); send(8'h00, 0);
    chk("max_no_err", 32'(load_err), 0);
    chk("max_ready", 32'(in_ready), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Empty frame
    base = wr_n;
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    chk("empty_core_run", 32'(core_run), 1);
    chk("empty_words_loaded", 32'(words_loaded), 0);
    chk("empty_no_write", 32'(wr_n - base), 0);
    pulse_reload();

    // rst after 2 of 4 bytes of word 1
    base = wr_n;
    send(8'h02, 0); send(8'h00, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    send(8'h55, 0); send(8'h66, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("rst_mid_wr_count", 32'(wr_n - base), 1);
    chk("rst_mid_addr0", wr_addr[base], 0);
    chk("rst_mid_data0", wr_data[base], 32'h4433_2211);
    chk("rst_mid_in_ready", 32'(in_ready), 1);
    chk("rst_mid_words_loaded", 32'(words_loaded), 0);
    chk("rst_mid_imem_we", 32'(imem_we), 0);
    chk("rst_mid_core_run", 32'(core_run), 0);

    // Fresh frame after rst: N=1, XOR DD^CC^BB^AA = 0x00
    base = wr_n;
    send(8'h01, 0); send(8'h00, 0);
    send(8'hDD, 0); send(8'hCC, 1); send(8'hBB, 0); send(8'hAA, 0);
    send(8'h00, 0);
    chk("fresh_wr_count", 32'(wr_n - base), 1);
    chk("fresh_addr", wr_addr[base], 0);
    chk("fresh_data", wr_data[base], 32'hAABB_CCDD);
    chk("fresh_core_run", 32'(core_run), 1);
    chk("fresh_words_loaded", 32'(words_loaded), 1);

    // reload then second image overwrites addr 0: XOR 78^56^34^12 = 0x08
    pulse_reload();
    chk("reload2_core_run", 32'(core_run), 0);
    base = wr_n;
    send(8'h01, 0); send(8'h00, 0);
    send(8'h78, 0); send(8'h56, 0); send(8'h34, 0); send(8'h12, 0);
    send(8'h08, 0);
    chk("second_addr", wr_addr[base], 0);
    chk("second_data", wr_data[base], 32'h1234_5678);
    chk("second_core_run", 32'(core_run), 1);

    // rst and reload together from DONE
    rst = 1'b1; reload = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; reload = 1'b0;
    chk("rst_reload_core_run", 32'(core_run), 0);
    chk("rst_reload_ready", 32'(in_ready), 1);
    chk("rst_reload_words", 32'(words_loaded), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
